phys_free_list: RTL

Physical-register free list for the out-of-order core. It allocates up to two physical destination registers per cycle to the rename stage. It reclaims registers from the per-cycle retirement free mask produced by the reorder buffer (`free_regs_r`, one bit per physical register). It sits between ROB retirement and rename: it is the downstream consumer of the ROB's freed-register mask and the upstream supplier of `curr_dest_reg` values.

---
 rtl/phys_free_list.sv | 131 +++++++++++++
 1 files changed

// File: rtl/phys_free_list.sv
// phys_free_list: physical-register free list between ROB retirement and rename.
// Grants up to two pregs per cycle (lowest free indices) and reclaims pregs
// from the per-cycle retirement free mask. Preg 0 is permanently reserved.
// Optional build macro FREE_LIST_DBL_FREE_CHK_EN adds the sticky double_free_o
// flag; without it double frees are silently absorbed.
module phys_free_list #(
    parameter  int NUM_PREGS = 64,
    parameter  int NUM_AREGS = 32,
    localparam int IDX_W     = $clog2(NUM_PREGS),
    localparam int CNT_W     = $clog2(NUM_PREGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           alloc_req_i,
    output logic                 alloc_gnt_o,
    output logic [IDX_W-1:0]     alloc_preg_1_o,
    output logic [IDX_W-1:0]     alloc_preg_2_o,
    input  logic [NUM_PREGS-1:0] free_mask_i,
    output logic [CNT_W-1:0]     free_count_o,
    output logic                 stall_o
`ifdef FREE_LIST_DBL_FREE_CHK_EN
    ,
    output logic                 double_free_o
`endif
);

    localparam logic [NUM_PREGS-1:0] RESET_VEC =
        {{(NUM_PREGS - NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
    localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(NUM_PREGS - NUM_AREGS);

    logic [NUM_PREGS-1:0] free_vec_q, free_vec_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [IDX_W-1:0]     preg_1, preg_2;
    logic                 found_1, found_2;
    logic                 gnt;
    logic [CNT_W-1:0]     num_granted;
    logic [NUM_PREGS-1:0] alloc_bits;
    logic [NUM_PREGS-1:0] freed_bits;
    logic [NUM_PREGS-1:0] newly_freed;
    logic [CNT_W-1:0]     newly_freed_cnt;

    // Pick the two lowest free indices from the registered free vector
    always_comb begin
        preg_1  = '0;
        preg_2  = '0;
        found_1 = 1'b0;
        found_2 = 1'b0;
        for (int unsigned i = 1; i < NUM_PREGS; i++) begin
            if (free_vec_q[i]) begin
                if (!found_1) begin
                    preg_1  = i[IDX_W-1:0];
                    found_1 = 1'b1;
                end else if (!found_2) begin
                    preg_2  = i[IDX_W-1:0];
                    found_2 = 1'b1;
                end
            end
        end
    end

    // All-or-nothing grant; req 2'b11 behaves as a request for two
    always_comb begin
        gnt         = 1'b0;
        num_granted = '0;
        alloc_bits  = '0;
        if (alloc_req_i == 2'b01 && count_q >= CNT_W'(1)) begin
            gnt         = 1'b1;
            num_granted = CNT_W'(1);
        end else if (alloc_req_i[1] && count_q >= CNT_W'(2)) begin
            gnt         = 1'b1;
            num_granted = CNT_W'(2);
        end
        if (gnt) begin
            alloc_bits[preg_1] = 1'b1;
            if (alloc_req_i[1]) begin
                alloc_bits[preg_2] = 1'b1;
            end
        end
    end

    // Next free vector and count; freed bits only become visible next cycle
    always_comb begin
        freed_bits      = free_mask_i & ~NUM_PREGS'(1);
        newly_freed     = freed_bits & ~free_vec_q;
        newly_freed_cnt = '0;
        for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            newly_freed_cnt = newly_freed_cnt + CNT_W'(newly_freed[i]);
        end
        free_vec_d = (free_vec_q & ~alloc_bits) | freed_bits;
        count_d    = count_q - num_granted + newly_freed_cnt;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_vec_q <= RESET_VEC;
            count_q    <= RESET_CNT;
        end else begin
            free_vec_q <= free_vec_d;
            count_q    <= count_d;
        end
    end

`ifdef FREE_LIST_DBL_FREE_CHK_EN
    logic dbl_free_q, dbl_free_d;

    // Sticky flag: set when any retired preg was already free
    always_comb begin
        dbl_free_d = dbl_free_q | (|(freed_bits & free_vec_q));
    end

    // Double-free flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbl_free_q <= 1'b0;
        end else begin
            dbl_free_q <= dbl_free_d;
        end
    end

    assign double_free_o = dbl_free_q;
`endif

    assign alloc_gnt_o    = gnt;
    assign alloc_preg_1_o = preg_1;
    assign alloc_preg_2_o = preg_2;
    assign free_count_o   = count_q;
    assign stall_o        = (count_q < CNT_W'(2));

endmodule
